sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM read master that interrogates a system-ID slave: reads word 0 (system ID) and word 1 (build timestamp).
- Compares both words against expected values and reports match/mismatch/timeout status to boot/health logic.
- Sits on the master side of the system-ID control slave and drives its address/read.
- Handles waitrequest stalls; readdata is accepted with read latency 0, i.e. in the cycle where read=1 and waitrequest=0.

Parameters:
- EXPECTED_ID, 32'h12345678, value required at slave word 0.
- EXPECTED_TIMESTAMP, 32'h5CDB3A3E, value required at slave word 1.
- TIMEOUT_CYCLES, 255, maximum stalled cycles per read before abort; legal range 1..65535.
- AUTO_START, 1, when 1 a check sequence launches automatically on the first cycle after reset deasserts.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; launches a check sequence when not busy.
- avm_address  out  1  word address to slave: 0 = ID, 1 = timestamp.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  slave read data, valid when avm_read=1 and avm_waitrequest=0.
- busy  out  1  sequence in progress.
- done  out  1  sticky: sequence finished, whether by completion or timeout.
- id_match  out  1  captured ID equals EXPECTED_ID.
- ts_match  out  1  captured timestamp equals EXPECTED_TIMESTAMP.
- timeout  out  1  sticky: a read exceeded TIMEOUT_CYCLES.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.

Behaviour:
- Reset: all outputs registered. While reset=1, every output is 0 and the FSM is held in IDLE; a start asserted during reset is ignored. Reset mid-read drops avm_read the next edge with no partial result kept.
- FSM states: IDLE, RD_ID, RD_TS, FINISH.
- IDLE:
  - Moves to RD_ID on start=1, or on the first post-reset cycle if AUTO_START=1.
  - On entry to RD_ID: clear done, timeout, id_match, ts_match, id_value, ts_value and the wait counter; set busy=1, avm_read=1, avm_address=0.
- RD_ID:
  - If avm_waitrequest=0: capture avm_readdata into id_value, set id_match=(avm_readdata==EXPECTED_ID), and go to RD_TS with avm_address=1 and avm_read held at 1.
  - Otherwise increment the wait counter.
- RD_TS: same as RD_ID, but capture into ts_value and ts_match; on acceptance go to FINISH and drop avm_read.
- Timeout:
  - In RD_ID or RD_TS, if waitrequest is still 1 when the counter equals TIMEOUT_CYCLES-1, go to FINISH with timeout=1 and avm_read=0.
  - The match flag for the aborted word stays 0.
  - The counter clears at each accepted read.
- FINISH: busy=0, done=1. Hold until start=1, then behave as IDLE+start: restart and clear the flags, going directly to RD_ID.
- Latency: with waitrequest tied 0 and start at edge N, avm_read=1 and address 0 after N+1; address 1 after N+2; done=1 after N+3.
- avm_address and avm_read change only on clock edges. Neither changes while waitrequest=1 (Avalon hold rule).
- start while busy=1 is ignored, with no re-queue.
- Outputs are stable in FINISH until the next start or reset.
- Width rules:
  - Comparisons are full 32-bit equality.
  - Wait counter width is $clog2(TIMEOUT_CYCLES+1), and it saturates rather than wrapping.

Decomposition:
- Shared package `sysid_pkg`:
  - FSM state enum.
  - Word address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1.
  - Default expected ID/timestamp constants, so they are shared with the slave generator.
- One natural sub-module, `sysid_wait_timer`: clearable saturating counter with a terminal-count output.
- All else in a single FSM file.

Test Plan:
- Zero-wait slave returning 0x12345678 and 0x5CDB3A3E, AUTO_START=1, reset released at cycle 0:
  - Address sequence is 0 then 1 on consecutive cycles.
  - done=1 at cycle 3, with id_match=1, ts_match=1, timeout=0, busy=0.
- Slave word 1 returns 0x00000000:
  - After start, done=1 with id_match=1, ts_match=0, ts_value=0.
- waitrequest held high for 5 cycles on each read:
  - avm_address and avm_read stay stable throughout each stall.
  - done occurs 13 cycles after start; both matches are 1.
- waitrequest stuck high, TIMEOUT_CYCLES=4:
  - avm_read drops after 4 stalled cycles in RD_ID.
  - timeout=1, done=1, id_match=0, ts_match=0, and address 1 is never issued.
- start pulsed while busy is ignored; a second start in FINISH clears done/flags within 1 cycle and reruns the sequence.
- reset=1 asserted during a stalled RD_TS:
  - avm_read=0 and all status outputs are 0 after the next edge.
  - With AUTO_START=1, the sequence restarts after reset drops.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker and the matching slave generator:
// FSM states, slave word map and default expected contents.
package sysid_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD_ID,
      S_RD_TS,
      S_FINISH
   } sysid_state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [31:0] SYSID_DEFAULT_ID = 32'h1234_5678;
   localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5CDB_3A3E;

endpackage

// File: rtl/sysid_wait_timer.sv
// Clearable saturating stall counter; terminal flags the last stall cycle
// a read may take before it is aborted.
module sysid_wait_timer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic terminal
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == LAST);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words,
// compares them to expected values and reports match / timeout status.
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
   parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_match,
   output logic        ts_match,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   sysid_state_t state, state_n;

   logic        auto_pend;
   logic        in_read, stall, accept, abort, launch, terminal;
   logic        avm_address_n, avm_read_n, busy_n, done_n;
   logic        id_match_n, ts_match_n, timeout_n;
   logic [31:0] id_value_n, ts_value_n;

   assign in_read = (state == S_RD_ID) || (state == S_RD_TS);
   assign stall   = in_read && avm_waitrequest;
   assign accept  = in_read && !avm_waitrequest;
   assign abort   = stall && terminal;
   assign launch  = ((state == S_IDLE) && (start || (AUTO_START && auto_pend)))
                 || ((state == S_FINISH) && start);

   sysid_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .clear    (launch || accept),
      .inc      (stall),
      .terminal (terminal)
   );

   // auto_pend is only high on the first cycle after reset releases
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         auto_pend   <= 1'b1;
         avm_address <= 1'b0;
         avm_read    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_match    <= 1'b0;
         ts_match    <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         state       <= state_n;
         auto_pend   <= 1'b0;
         avm_address <= avm_address_n;
         avm_read    <= avm_read_n;
         busy        <= busy_n;
         done        <= done_n;
         id_match    <= id_match_n;
         ts_match    <= ts_match_n;
         timeout     <= timeout_n;
         id_value    <= id_value_n;
         ts_value    <= ts_value_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (launch) state_n = S_RD_ID;
         S_RD_ID:  if (accept) state_n = S_RD_TS;
                   else if (abort) state_n = S_FINISH;
                   else state_n = S_RD_ID;
         S_RD_TS:  if (accept || abort) state_n = S_FINISH;
         S_FINISH: if (start) state_n = S_RD_ID;
         default:  state_n = S_IDLE;
      endcase
   end

   always_comb begin
      avm_address_n = avm_address;
      avm_read_n    = avm_read;
      busy_n        = busy;
      done_n        = done;
      id_match_n    = id_match;
      ts_match_n    = ts_match;
      timeout_n     = timeout;
      id_value_n    = id_value;
      ts_value_n    = ts_value;

      if (launch) begin
         avm_address_n = SYSID_ADDR_ID;
         avm_read_n    = 1'b1;
         busy_n        = 1'b1;
         done_n        = 1'b0;
         id_match_n    = 1'b0;
         ts_match_n    = 1'b0;
         timeout_n     = 1'b0;
         id_value_n    = '0;
         ts_value_n    = '0;
      end

      if (accept && (state == S_RD_ID)) begin
         id_value_n    = avm_readdata;
         id_match_n    = (avm_readdata == EXPECTED_ID);
         avm_address_n = SYSID_ADDR_TS;
      end

      if (accept && (state == S_RD_TS)) begin
         ts_value_n = avm_readdata;
         ts_match_n = (avm_readdata == EXPECTED_TIMESTAMP);
         avm_read_n = 1'b0;
         busy_n     = 1'b0;
         done_n     = 1'b1;
      end

      // aborted word keeps its match flag at 0 from launch
      if (abort) begin
         avm_read_n = 1'b0;
         busy_n     = 1'b0;
         done_n     = 1'b1;
         timeout_n  = 1'b1;
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: a transaction-level model checked every cycle on the
// default instance, plus a short-timeout instance driven by directed vectors.
module tb_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'h1234_5678;
   localparam logic [31:0] EXP_TS = 32'h5CDB_3A3E;
   localparam int          TO_A   = 255;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start_b = 1'b0;

   logic        addr_a, read_a, wait_a, busy_a, done_a, idm_a, tsm_a, to_a;
   logic [31:0] rdata_a, idv_a, tsv_a;
   logic        addr_b, read_b, wait_b, busy_b, done_b, idm_b, tsm_b, to_b;
   logic [31:0] rdata_b, idv_b, tsv_b;

   logic [31:0] ts_word = EXP_TS;
   int          stall_cfg = 0;
   int          scnt;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clock = ~clock;

   sysid_checker dut_a (
      .clock(clock), .reset(reset), .start(start),
      .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wait_a),
      .avm_readdata(rdata_a), .busy(busy_a), .done(done_a),
      .id_match(idm_a), .ts_match(tsm_a), .timeout(to_a),
      .id_value(idv_a), .ts_value(tsv_a)
   );

   sysid_checker #(.TIMEOUT_CYCLES(4), .AUTO_START(1'b0)) dut_b (
      .clock(clock), .reset(reset), .start(start_b),
      .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wait_b),
      .avm_readdata(rdata_b), .busy(busy_b), .done(done_b),
      .id_match(idm_b), .ts_match(tsm_b), .timeout(to_b),
      .id_value(idv_b), .ts_value(tsv_b)
   );

   // slave A: stalls stall_cfg cycles on every read, then returns the word
   assign rdata_a = addr_a ? ts_word : EXP_ID;
   assign wait_a  = (scnt < stall_cfg);
   assign wait_b  = 1'b1;
   assign rdata_b = EXP_ID;

   always @(posedge clock) begin
      if (reset) scnt <= 0;
      else if (read_a && wait_a) scnt <= scnt + 1;
      else scnt <= 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // transaction-level model of instance A
   logic        m_busy, m_read, m_addr, m_done, m_idm, m_tsm, m_to, m_pend;
   logic [31:0] m_idv, m_tsv;
   int          m_stall;

   always @(posedge clock) begin
      if (reset) begin
         m_busy <= 0; m_read <= 0; m_addr <= 0; m_done <= 0;
         m_idm <= 0; m_tsm <= 0; m_to <= 0; m_idv <= 0; m_tsv <= 0;
         m_pend <= 1; m_stall <= 0;
      end else begin
         m_pend <= 0;
         if (!m_busy && (start || m_pend)) begin
            m_busy <= 1; m_read <= 1; m_addr <= 0; m_done <= 0;
            m_idm <= 0; m_tsm <= 0; m_to <= 0; m_idv <= 0; m_tsv <= 0;
            m_stall <= 0;
         end else if (m_busy && !wait_a) begin
            m_stall <= 0;
            if (!m_addr) begin
               m_idv <= EXP_ID; m_idm <= 1; m_addr <= 1;
            end else begin
               m_tsv <= ts_word; m_tsm <= (ts_word == EXP_TS);
               m_busy <= 0; m_read <= 0; m_done <= 1;
            end
         end else if (m_busy) begin
            if (m_stall + 1 == TO_A) begin
               m_busy <= 0; m_read <= 0; m_done <= 1; m_to <= 1;
            end else begin
               m_stall <= m_stall + 1;
            end
         end
      end
   end

   logic p_stall = 1'b0;
   logic p_addr  = 1'b0;

   always @(negedge clock) begin
      if (chk_en) begin
         chk("m_read", 32'(read_a), 32'(m_read));
         chk("m_addr", 32'(addr_a), 32'(m_addr));
         chk("m_busy", 32'(busy_a), 32'(m_busy));
         chk("m_done", 32'(done_a), 32'(m_done));
         chk("m_idm", 32'(idm_a), 32'(m_idm));
         chk("m_tsm", 32'(tsm_a), 32'(m_tsm));
         chk("m_timeout", 32'(to_a), 32'(m_to));
         chk("m_idv", idv_a, m_idv);
         chk("m_tsv", tsv_a, m_tsv);
         if (p_stall) begin
            chk("hold_read", 32'(read_a), 32'd1);
            chk("hold_addr", 32'(addr_a), 32'(p_addr));
         end
      end
      p_stall <= read_a && wait_a && !reset;
      p_addr  <= addr_a;
   end

   task automatic edge_drive;
      @(posedge clock);
      #1;
   endtask

   task automatic run_start(output int n);
      edge_drive();
      start = 1'b1;
      n = 0;
      for (int k = 0; k < 60; k++) begin
         edge_drive();
         start = 1'b0;
         n++;
         @(negedge clock);
         if (done_a) break;
      end
   endtask

   initial begin
      int n, nr;
      bit saw;
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, nr;
      bit saw;
      // reset, with a start that must be ignored
      edge_drive();
      chk_en = 1'b1;
      start = 1'b1;
      edge_drive();
      start = 1'b0;
      edge_drive();
      @(negedge clock);
      chk("rst_read", 32'(read_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_idv", idv_a, 32'd0);

      // auto start, zero-wait slave
      edge_drive();
      reset = 1'b0;
      edge_drive();
      @(negedge clock);
      chk("auto_c1_read", 32'(read_a), 32'd1);
      chk("auto_c1_addr", 32'(addr_a), 32'd0);
      edge_drive();
      @(negedge clock);
      chk("auto_c2_addr", 32'(addr_a), 32'd1);
      edge_drive();
      @(negedge clock);
      chk("auto_c3_done", 32'(done_a), 32'd1);
      chk("auto_c3_flags", {28'd0, idm_a, tsm_a, to_a, busy_a}, 32'b1100);
      chk("auto_c3_tsv", tsv_a, 32'h5CDB_3A3E);

      // wrong timestamp word
      ts_word = 32'h0;
      run_start(n);
      chk("badts_latency", 32'(n), 32'd3);
      chk("badts_flags", {30'd0, idm_a, tsm_a}, 32'b10);
      chk("badts_tsv", tsv_a, 32'h0);
      ts_word = EXP_TS;

      // 5-cycle stall on every read
      stall_cfg = 5;
      run_start(n);
      chk("stall_latency", 32'(n), 32'd13);
      chk("stall_flags", {30'd0, idm_a, tsm_a}, 32'b11);

      // start while busy is ignored
      edge_drive();
      start = 1'b1;
      edge_drive();
      start = 1'b0;
      repeat (3) edge_drive();
      start = 1'b1;
      edge_drive();
      start = 1'b0;
      n = 5;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (done_a) break;
         edge_drive();
         n++;
      end
      chk("busy_start_latency", 32'(n), 32'd13);

      // restart from FINISH clears flags within one cycle
      stall_cfg = 0;
      edge_drive();
      start = 1'b1;
      edge_drive();
      start = 1'b0;
      @(negedge clock);
      chk("restart_done", 32'(done_a), 32'd0);
      chk("restart_busy", 32'(busy_a), 32'd1);
      chk("restart_idv", idv_a, 32'd0);
      repeat (2) edge_drive();
      @(negedge clock);
      chk("restart_fin", {30'd0, done_a, idm_a}, 32'b11);

      // reset during a stalled timestamp read
      stall_cfg = 5;
      edge_drive();
      start = 1'b1;
      edge_drive();
      start = 1'b0;
      saw = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (addr_a) begin saw = 1'b1; break; end
      end
      chk("rst_mid_reach_ts", 32'(saw), 32'd1);
      edge_drive();
      reset = 1'b1;
      edge_drive();
      @(negedge clock);
      chk("rst_mid_read", 32'(read_a), 32'd0);
      chk("rst_mid_status", {27'd0, busy_a, done_a, idm_a, tsm_a, to_a}, 32'd0);
      chk("rst_mid_idv", idv_a, 32'd0);
      edge_drive();
      reset = 1'b0;
      edge_drive();
      @(negedge clock);
      chk("rst_auto_read", 32'(read_a), 32'd1);
      n = 1;
      for (int k = 0; k < 40; k++) begin
         if (done_a) break;
         edge_drive();
         n++;
         @(negedge clock);
      end
      chk("rst_auto_latency", 32'(n), 32'd13);
      chk("rst_auto_flags", {30'd0, idm_a, tsm_a}, 32'b11);

      // instance B: stuck waitrequest, timeout after 4 stalls
      edge_drive();
      start_b = 1'b1;
      edge_drive();
      start_b = 1'b0;
      @(negedge clock);
      chk("to_c1_read", 32'(read_b), 32'd1);
      chk("to_c1_busy", 32'(busy_b), 32'd1);
      n = 1; nr = 0; saw = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (read_b) nr++;
         if (addr_b) saw = 1'b1;
         if (done_b) break;
         edge_drive();
         n++;
         @(negedge clock);
      end
      chk("to_latency", 32'(n), 32'd5);
      chk("to_read_cycles", 32'(nr), 32'd4);
      chk("to_addr1_seen", 32'(saw), 32'd0);
      chk("to_flags", {27'd0, to_b, done_b, idm_b, tsm_b, busy_b}, 32'b11000);
      chk("to_read_dropped", 32'(read_b), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
